dds_phase_core: RTL and testbench
=================================

Name: dds_phase_core

Overview:
- Downstream of the frequency sweeper; consumes its tuning word and update strobe.
- Runs a 32-bit phase accumulator and produces a signed sine sample through a quarter-wave LUT pipeline.
- Computes the signed phase error against an external reference phase. This error feeds back to the sweeper's PLL phase_error input.

Parameters:
- ACC_W, 32, phase accumulator and tuning word width.
- PHASE_W, 12, truncated phase bits used to address the sine table (full cycle = 2^PHASE_W points).
- OUT_W, 16, signed sine sample width.
- ERR_W, 16, phase_out, ref_phase and phase_error width.

Ports:
- clk  in  1  system clock (50 MHz).
- reset  in  1  synchronous, active-high reset.
- enable  in  1  advance accumulator and launch a pipeline token this cycle.
- freq_word  in  ACC_W  tuning word (from dds_freq).
- freq_valid  in  1  one-cycle strobe; latch freq_word (from frequency_update).
- sync_clear  in  1  one-cycle strobe; zero the accumulator (from sweep_start).
- ref_phase  in  ERR_W  reference phase, unsigned fraction of a turn.
- phase_out  out  ERR_W  acc[ACC_W-1 -: ERR_W], registered.
- sine_out  out  OUT_W  signed sine sample.
- sine_valid  out  1  sine_out valid.
- phase_error  out  ERR_W  signed ref_phase - phase_out.
- err_valid  out  1  phase_error valid.

Behaviour:
- Reset (synchronous, active-high): all outputs, the accumulator, the active word register and all pipeline valids are 0.
- Reset asserted mid-stream flushes in-flight tokens; no valid pulse survives reset.
- Word latch: on freq_valid, active_word <= freq_word. The new word is first added on the following enabled cycle.
- Accumulator: on enable, acc <= acc + active_word, modulo 2^ACC_W (natural wrap, no saturation).
- Priority when sync_clear is asserted:
  - acc <= 0 regardless of enable.
  - A coincident freq_valid still latches the word.
  - The next enabled cycle adds the new word.
- Sine pipeline (one token per enabled cycle, valid bit shifts with data):
  - S1: register addr = acc[ACC_W-1 -: PHASE_W]. Quadrant = addr[PHASE_W-1:PHASE_W-2], idx = low PHASE_W-2 bits.
  - S2: quadrants 1 and 3 use idx = ~idx (mirror). Registered LUT read.
  - S3: quadrants 2 and 3 negate the sample. sine_out registered.
- Latency: sine_out / sine_valid appear 3 cycles after the acc update.
- sine_valid is high exactly for tokens launched with enable; it holds 0 when enable is low.
- LUT contents: entry i = round((2^(OUT_W-1)-1) * sin(2π(i+0.5)/2^PHASE_W)), i = 0..2^(PHASE_W-2)-1.
  - Negation never overflows.
  - Output is symmetric; there is no zero entry.
- Phase error:
  - phase_out is registered together with acc.
  - phase_error = ref_phase - phase_out, modulo 2^ERR_W, read as two's complement. This gives the shortest error in [-2^(ERR_W-1), 2^(ERR_W-1)-1].
  - 1 cycle after phase_out; err_valid = enable delayed 1.
  - 0x8000 difference reports -32768.
- enable low: accumulator, phase_out and phase_error hold; valids deassert.

Optional Feature:
- Macro: DDS_PHASE_DITHER_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 0xACE1; reset reloads the seed) advances on enable.
  - Its low (ACC_W-PHASE_W) bits are added to acc before truncation in S1, to spread spurs.
  - phase_out and phase_error are NOT dithered.
- Undefined: no LFSR; plain truncation.

Decomposition:
- Package dds_pkg:
  - Width constants (ACC_W, PHASE_W, OUT_W, ERR_W defaults).
  - Quadrant typedef (Q0..Q3).
  - LFSR seed and taps.
- Sub-module dds_sine_lut:
  - Registered quarter-wave ROM.
  - Input idx; output magnitude; 1-cycle read.
  - Contents generated by a function or initial block.

Test Plan:
- Reset then freq_word=0x0010_0000, freq_valid, sync_clear, enable held:
  - addr increments by 1 per cycle.
  - First sine_valid 3 cycles after the first acc update.
  - sine_out peaks at 32767 near addr 1023/1024 and reaches -32767 near addr 3071/3072.
- freq_word=0x4000_0000: phase_out sequence 0x4000, 0x8000, 0xC000, 0x0000 (wrap). sine_out sign pattern +,+,-,- repeating.
- freq_word=0, sync_clear, ref_phase=0x0100 -> phase_error=0x0100 (+256). Set acc so phase_out=0xFFF0 with ref_phase=0x0000 -> phase_error=+16.
- freq_valid and sync_clear in the same cycle with a new word 0x0800_0000 -> acc=0, then 0x0800_0000 on the next enabled cycle.
- Toggle enable 1,0,1 -> sine_valid pattern 1,0,1 delayed 3 cycles. acc holds in the disabled cycle.
- Assert reset with 2 tokens in flight -> no sine_valid/err_valid afterward; all outputs 0 the cycle after reset.

Source files
------------

// File: rtl/dds_pkg.sv
// dds_pkg: shared width defaults, quadrant encoding and the sine-table generator.
// The LFSR constants exist only when DDS_PHASE_DITHER_EN is defined.
package dds_pkg;

    localparam int DEF_ACC_W   = 32;
    localparam int DEF_PHASE_W = 12;
    localparam int DEF_OUT_W   = 16;
    localparam int DEF_ERR_W   = 16;

    localparam real PI = 3.14159265358979323846;

    typedef enum logic [1:0] {
        Q0,
        Q1,
        Q2,
        Q3
    } quadrant_t;

`ifdef DDS_PHASE_DITHER_EN
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 expressed as a mask over bits [15:0].
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
`endif

    // Quarter-wave entry: round((2^(out_w-1)-1) * sin(2*pi*(i+0.5)/2^phase_w)).
    // Every argument lies strictly inside the first quadrant, so the value is positive.
    function automatic int sine_entry(input int i, input int phase_w, input int out_w);
        return $rtoi(real'((1 << (out_w - 1)) - 1)
                     * $sin(2.0 * PI * (real'(i) + 0.5) / real'(1 << phase_w)) + 0.5);
    endfunction

endpackage

// File: rtl/dds_sine_lut.sv
// dds_sine_lut: registered quarter-wave sine magnitude ROM with a one-cycle read.
// The half-step sample offset makes the table symmetric with no zero entry.
module dds_sine_lut
    import dds_pkg::*;
#(
    parameter int PHASE_W = DEF_PHASE_W,
    parameter int OUT_W   = DEF_OUT_W
) (
    input  logic               clk,
    input  logic [PHASE_W-3:0] idx,
    output logic [OUT_W-2:0]   mag
);

    localparam int DEPTH = 1 << (PHASE_W - 2);

    logic [OUT_W-2:0] rom [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        assign rom[i] = (OUT_W - 1)'(sine_entry(i, PHASE_W, OUT_W));
    end

    // NOTE: the table and its read register carry no reset; the pipeline valids
    // are reset instead, so stale magnitudes are never presented as valid.
    always_ff @(posedge clk) begin
        mag <= rom[idx];
    end

endmodule

// File: rtl/dds_phase_core.sv
// dds_phase_core: 32-bit phase accumulator, 3-stage quarter-wave sine pipeline and
// signed phase error against ref_phase. Define DDS_PHASE_DITHER_EN for LFSR phase dither.
module dds_phase_core
    import dds_pkg::*;
#(
    parameter int ACC_W   = DEF_ACC_W,
    parameter int PHASE_W = DEF_PHASE_W,
    parameter int OUT_W   = DEF_OUT_W,
    parameter int ERR_W   = DEF_ERR_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [ACC_W-1:0] freq_word,
    input  logic             freq_valid,
    input  logic             sync_clear,
    input  logic [ERR_W-1:0] ref_phase,
    output logic [ERR_W-1:0] phase_out,
    output logic [OUT_W-1:0] sine_out,
    output logic             sine_valid,
    output logic [ERR_W-1:0] phase_error,
    output logic             err_valid
);

    localparam int IDX_W = PHASE_W - 2;

    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   active_word;
    logic               acc_valid;

    logic [PHASE_W-1:0] s1_next;
    logic [PHASE_W-1:0] s1_addr;
    logic               s1_valid;
    quadrant_t          s1_quad;
    logic [IDX_W-1:0]   s1_idx;
    logic [IDX_W-1:0]   lut_idx;

    quadrant_t          s2_quad;
    logic               s2_valid;
    logic [OUT_W-2:0]   s2_mag;
    logic [OUT_W-1:0]   mag_ext;

    // ------------------------------------------------------------------
    // Tuning word and accumulator
    // ------------------------------------------------------------------
    // NOTE: non-blocking updates mean a word latched this cycle is not seen by
    // the accumulator until the next enabled cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            active_word <= '0;
            acc         <= '0;
            acc_valid   <= 1'b0;
        end else begin
            if (freq_valid) begin
                active_word <= freq_word;
            end
            if (sync_clear) begin
                acc <= '0;
            end else if (enable) begin
                acc <= acc + active_word;
            end
            acc_valid <= enable;
        end
    end

    assign phase_out = acc[ACC_W-1 -: ERR_W];

    // ------------------------------------------------------------------
    // Optional phase dither (sine path only)
    // ------------------------------------------------------------------
`ifdef DDS_PHASE_DITHER_EN
    localparam logic [ACC_W-1:0] DITHER_MASK = (ACC_W'(1) << (ACC_W - PHASE_W)) - ACC_W'(1);

    logic [15:0]      lfsr;
    logic [ACC_W-1:0] dithered;

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= LFSR_SEED;
        end else if (enable) begin
            lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
        end
    end

    assign dithered = acc + (ACC_W'(lfsr) & DITHER_MASK);
    assign s1_next  = dithered[ACC_W-1 -: PHASE_W];
`else
    assign s1_next = acc[ACC_W-1 -: PHASE_W];
`endif

    // ------------------------------------------------------------------
    // S1: truncated phase address
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_addr  <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_addr  <= s1_next;
            s1_valid <= acc_valid;
        end
    end

    // NOTE: every output of this block gets a default first, so no latch can form.
    always_comb begin
        s1_quad = quadrant_t'(s1_addr[PHASE_W-1 -: 2]);
        s1_idx  = s1_addr[IDX_W-1:0];
        lut_idx = s1_idx;
        if ((s1_quad == Q1) || (s1_quad == Q3)) begin
            lut_idx = ~s1_idx;
        end
    end

    // ------------------------------------------------------------------
    // S2: mirrored table read, quadrant travels alongside
    // ------------------------------------------------------------------
    dds_sine_lut #(
        .PHASE_W (PHASE_W),
        .OUT_W   (OUT_W)
    ) u_lut (
        .clk (clk),
        .idx (lut_idx),
        .mag (s2_mag)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_quad  <= Q0;
            s2_valid <= 1'b0;
        end else begin
            s2_quad  <= s1_quad;
            s2_valid <= s1_valid;
        end
    end

    // ------------------------------------------------------------------
    // S3: sign restore; magnitude tops out at 2^(OUT_W-1)-1, so negation is safe
    // ------------------------------------------------------------------
    assign mag_ext = {1'b0, s2_mag};

    always_ff @(posedge clk) begin
        if (reset) begin
            sine_out   <= '0;
            sine_valid <= 1'b0;
        end else begin
            sine_out   <= ((s2_quad == Q2) || (s2_quad == Q3)) ? -mag_ext : mag_ext;
            sine_valid <= s2_valid;
        end
    end

    // ------------------------------------------------------------------
    // Phase error: wrap-around difference read as two's complement
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_error <= '0;
            err_valid   <= 1'b0;
        end else begin
            if (acc_valid) begin
                phase_error <= ref_phase - phase_out;
            end
            err_valid <= acc_valid;
        end
    end

endmodule

// File: tb/tb_dds_phase_core.sv
// tb_dds_phase_core: scoreboard bench for dds_phase_core (default build, no dither).
// Expected sine and error tokens are queued at stimulus time and popped when due.
module tb_dds_phase_core;

    localparam real TWO_PI = 6.283185307179586;

    typedef struct {
        int due;
        int val;
    } tok_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [31:0] freq_word;
    logic        freq_valid;
    logic        sync_clear;
    logic [15:0] ref_phase;
    logic [15:0] phase_out;
    logic [15:0] sine_out;
    logic        sine_valid;
    logic [15:0] phase_error;
    logic        err_valid;

    int   checks     = 0;
    int   failures   = 0;
    int   cyc        = 0;
    bit   monitor_on = 1'b0;
    tok_t sine_q[$];
    tok_t err_q[$];
    logic [31:0] m_acc  = '0;
    logic [31:0] m_word = '0;

    dds_phase_core dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .freq_word   (freq_word),
        .freq_valid  (freq_valid),
        .sync_clear  (sync_clear),
        .ref_phase   (ref_phase),
        .phase_out   (phase_out),
        .sine_out    (sine_out),
        .sine_valid  (sine_valid),
        .phase_error (phase_error),
        .err_valid   (err_valid)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Full-cycle reference: round(32767 * sin(2*pi*(addr+0.5)/4096)), rounding half away from zero.
    function automatic int sine_ref(input logic [11:0] addr);
        real x;
        x = 32767.0 * $sin(TWO_PI * (real'(addr) + 0.5) / 4096.0);
        if (x >= 0.0) return $rtoi(x + 0.5);
        else          return -$rtoi(0.5 - x);
    endfunction

    // Scoreboard consumer, sampled on the falling edge.
    always @(negedge clk) begin
        bit   exp_s;
        bit   exp_e;
        tok_t t;
        if (monitor_on) begin
            exp_s = (sine_q.size() != 0) && (sine_q[0].due == cyc);
            checks++;
            if (sine_valid !== exp_s) begin
                failures++;
                $display("FAIL sine_valid cycle=%0d got=%b want=%b", cyc, sine_valid, exp_s);
            end
            if (exp_s) begin
                t = sine_q.pop_front();
                checks++;
                if (int'($signed(sine_out)) !== t.val) begin
                    failures++;
                    $display("FAIL sine_out cycle=%0d got=%0d want=%0d", cyc, $signed(sine_out), t.val);
                end
            end

            exp_e = (err_q.size() != 0) && (err_q[0].due == cyc);
            checks++;
            if (err_valid !== exp_e) begin
                failures++;
                $display("FAIL err_valid cycle=%0d got=%b want=%b", cyc, err_valid, exp_e);
            end
            if (exp_e) begin
                t = err_q.pop_front();
                checks++;
                if (int'(phase_error) !== t.val) begin
                    failures++;
                    $display("FAIL phase_error cycle=%0d got=0x%04h want=0x%04h", cyc, phase_error, t.val);
                end
            end
        end
    end

    // One clock of stimulus: drive, advance the model, queue tokens, then check phase_out.
    task automatic drive(input logic rst, input logic en, input logic fv, input logic sc,
                         input logic [31:0] fw);
        logic [15:0] d;
        reset      = rst;
        enable     = en;
        freq_valid = fv;
        sync_clear = sc;
        freq_word  = fw;
        if (rst) begin
            m_acc  = '0;
            m_word = '0;
            while (sine_q.size() != 0 && sine_q[sine_q.size()-1].due > cyc)
                sine_q.delete(sine_q.size() - 1);
            while (err_q.size() != 0 && err_q[err_q.size()-1].due > cyc)
                err_q.delete(err_q.size() - 1);
        end else begin
            if (sc)      m_acc = '0;
            else if (en) m_acc = m_acc + m_word;
            if (fv)      m_word = fw;
            if (en) begin
                sine_q.push_back('{cyc + 4, sine_ref(m_acc[31:20])});
                d = ref_phase - m_acc[31:16];
                err_q.push_back('{cyc + 2, int'(d)});
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (phase_out !== m_acc[31:16]) begin
            failures++;
            $display("FAIL phase_out cycle=%0d got=0x%04h want=0x%04h", cyc, phase_out, m_acc[31:16]);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_reset();
        repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        checks += 5;
        if (sine_out !== 16'h0)    begin failures++; $display("FAIL reset_sine_out got=0x%04h want=0x0000", sine_out); end
        if (sine_valid !== 1'b0)   begin failures++; $display("FAIL reset_sine_valid got=%b want=0", sine_valid); end
        if (phase_error !== 16'h0) begin failures++; $display("FAIL reset_phase_error got=0x%04h want=0x0000", phase_error); end
        if (err_valid !== 1'b0)    begin failures++; $display("FAIL reset_err_valid got=%b want=0", err_valid); end
        if (phase_out !== 16'h0)   begin failures++; $display("FAIL reset_phase_out got=0x%04h want=0x0000", phase_out); end
    endtask

    // One full turn at one address step per cycle; covers both peaks and the wrap.
    task automatic test_sweep();
        drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h0010_0000);
        repeat (4100) drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        idle(5);
    endtask

    task automatic test_quarter();
        logic [15:0] seq [4];
        seq[0] = 16'h4000; seq[1] = 16'h8000; seq[2] = 16'hC000; seq[3] = 16'h0000;
        drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h4000_0000);
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
            checks++;
            if (phase_out !== seq[i % 4]) begin
                failures++;
                $display("FAIL quarter_phase step=%0d got=0x%04h want=0x%04h", i, phase_out, seq[i % 4]);
            end
        end
        idle(5);
    endtask

    task automatic test_phase_error();
        ref_phase = 16'h0100;
        drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
        repeat (3) drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        idle(5);
        checks++;
        if (phase_error !== 16'h0100) begin
            failures++; $display("FAIL err_plus256 got=0x%04h want=0x0100", phase_error);
        end

        ref_phase = 16'h0000;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'hFFF0_0000);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        idle(5);
        checks++;
        if (int'($signed(phase_error)) !== 16) begin
            failures++; $display("FAIL err_wrap_plus16 got=%0d want=16", $signed(phase_error));
        end

        drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h8000_0000);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        idle(5);
        checks++;
        if (int'($signed(phase_error)) !== -32768) begin
            failures++; $display("FAIL err_half_turn got=%0d want=-32768", $signed(phase_error));
        end
    endtask

    task automatic test_word_priority();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0100_0000);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h0800_0000);
        checks++;
        if (phase_out !== 16'h0000) begin
            failures++; $display("FAIL prio_clear got=0x%04h want=0x0000", phase_out);
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        checks++;
        if (phase_out !== 16'h0800) begin
            failures++; $display("FAIL prio_new_word got=0x%04h want=0x0800", phase_out);
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        idle(5);
    endtask

    task automatic test_enable_toggle();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checks++;
        if (phase_out !== 16'h1800) begin
            failures++; $display("FAIL toggle_hold got=0x%04h want=0x1800", phase_out);
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        idle(5);
    endtask

    task automatic test_reset_flush();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        checks += 4;
        if (sine_out !== 16'h0)    begin failures++; $display("FAIL flush_sine_out got=0x%04h want=0x0000", sine_out); end
        if (sine_valid !== 1'b0)   begin failures++; $display("FAIL flush_sine_valid got=%b want=0", sine_valid); end
        if (phase_error !== 16'h0) begin failures++; $display("FAIL flush_phase_error got=0x%04h want=0x0000", phase_error); end
        if (err_valid !== 1'b0)    begin failures++; $display("FAIL flush_err_valid got=%b want=0", err_valid); end
        idle(6);
    endtask

    initial begin
        reset      = 1'b1;
        enable     = 1'b0;
        freq_word  = '0;
        freq_valid = 1'b0;
        sync_clear = 1'b0;
        ref_phase  = '0;

        test_reset();
        monitor_on = 1'b1;
        test_sweep();
        test_quarter();
        test_phase_error();
        test_word_priority();
        test_enable_toggle();
        test_reset_flush();
        idle(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
